// File: rtl/uart_rx_hamming13.sv
// uart_rx_hamming13
// Receives pairs of 8N1 UART bytes, joins them into one 13-bit Hamming
// codeword and applies SECDED decoding.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   rx_serial     UART line, idle high, asynchronous to clk
//   data_out      decoded byte, held until the next data_valid
//   data_valid    one-cycle strobe when data_out and the error flags update
//   err_corrected single-bit error was corrected (qualified by data_valid)
//   err_double    uncorrectable error detected (qualified by data_valid)
//   frame_err     one-cycle strobe: bad stop bit or inter-byte gap timeout
//
// Codeword: code[12:5] = first (high) byte, code[4:0] = second byte[7:3].
// code[i], i=1..12, is Hamming position i; parity at 1,2,4,8; code[0] is
// overall parity.
module uart_rx_hamming13 #(
    parameter int unsigned CLKS_PER_BIT     = 8,
    parameter int unsigned GAP_TIMEOUT_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       err_corrected,
    output logic       err_double,
    output logic       frame_err
);

    localparam int unsigned GAP_CYCLES = GAP_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CW         = $clog2(GAP_CYCLES + CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_DECODE = 3'd5;
    // Holds after a bad stop bit until the line returns high.
    localparam logic [2:0] ST_BREAK  = 3'd6;

    // Synchronizer resets to the idle line level so reset never looks like a start.
    logic rx_meta_q, rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_s      <= rx_meta_q;
        end
    end

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] clk_count_q, clk_count_d;
    logic [CW-1:0] gap_count_q, gap_count_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    high_q, high_d;
    logic [7:0]    low_q, low_d;
    logic          have_high_q, have_high_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          corr_q, corr_d;
    logic          dbl_q, dbl_d;
    logic          ferr_q, ferr_d;

    // SECDED decode of the assembled codeword.
    logic [12:0] code, fixed;
    logic [3:0]  syn;
    logic        par;
    logic        dec_corr, dec_dbl;
    logic [7:0]  dec_data;

    always_comb begin
        code   = {high_q, low_q[7:3]};
        syn[0] = code[1] ^ code[3] ^ code[5] ^ code[7] ^ code[9] ^ code[11];
        syn[1] = code[2] ^ code[3] ^ code[6] ^ code[7] ^ code[10] ^ code[11];
        syn[2] = code[4] ^ code[5] ^ code[6] ^ code[7] ^ code[12];
        syn[3] = code[8] ^ code[9] ^ code[10] ^ code[11] ^ code[12];
        par    = ^code;
        // Odd overall parity with a syndrome inside the codeword means one flipped bit;
        // syndrome 0 then points at code[0], which carries no data.
        dec_corr = par && (syn <= 4'd12);
        dec_dbl  = (syn != 4'd0) && !dec_corr;
        fixed    = code;
        if (dec_corr && (syn != 4'd0)) begin
            fixed[syn] = ~code[syn];
        end
        dec_data = {fixed[12], fixed[11], fixed[10], fixed[9],
                    fixed[7], fixed[6], fixed[5], fixed[3]};
    end

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        gap_count_d = gap_count_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        high_d      = high_q;
        low_d       = low_q;
        have_high_d = have_high_q;
        data_out_d  = data_out_q;
        corr_d      = corr_q;
        dbl_d       = dbl_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d     = ST_START;
                    clk_count_d = '0;
                end
            end
            ST_START: begin
                if (clk_count_q == HALF_BIT) begin
                    clk_count_d = '0;
                    if (rx_s) begin
                        // False start: resume whatever we were waiting in.
                        state_d = have_high_q ? ST_GAP : ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_count_q == FULL_BIT) begin
                    clk_count_d = '0;
                    shift_d     = {shift_q[6:0], rx_s};  // MSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (clk_count_q == FULL_BIT) begin
                    clk_count_d = '0;
                    if (!rx_s) begin
                        ferr_d      = 1'b1;
                        have_high_d = 1'b0;
                        state_d     = ST_BREAK;
                    end else if (!have_high_q) begin
                        high_d      = shift_q;
                        have_high_d = 1'b1;
                        gap_count_d = '0;
                        state_d     = ST_GAP;
                    end else begin
                        low_d       = shift_q;
                        have_high_d = 1'b0;
                        state_d     = ST_DECODE;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                // Counts 0..GAP_LAST-1 form the accept window; GAP_LAST is the timeout cycle.
                if (gap_count_q == GAP_LAST) begin
                    ferr_d      = 1'b1;
                    have_high_d = 1'b0;
                    gap_count_d = '0;
                    state_d     = ST_IDLE;
                end else if (!rx_s) begin
                    state_d     = ST_START;
                    clk_count_d = '0;
                end else begin
                    gap_count_d = gap_count_q + CNT_ONE;
                end
            end
            ST_DECODE: begin
                data_out_d = dec_data;
                corr_d     = dec_corr;
                dbl_d      = dec_dbl;
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clk_count_q <= '0;
            gap_count_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            have_high_q <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            corr_q      <= 1'b0;
            dbl_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            gap_count_q <= gap_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            high_q      <= high_d;
            low_q       <= low_d;
            have_high_q <= have_high_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            corr_q      <= corr_d;
            dbl_q       <= dbl_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = valid_q;
    assign err_corrected = corr_q;
    assign err_double    = dbl_q;
    assign frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_rx_hamming13.sv
// Testbench for uart_rx_hamming13: directed cases followed by random codewords
// with 0, 1 or 2 injected bit errors, checked against a SECDED model.
module tb_uart_rx_hamming13;

    localparam int CPB = 8;
    localparam int GTB = 4;
    localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, err_corrected, err_double, frame_err;

    int total = 0;
    int bad   = 0;

    uart_rx_hamming13 #(
        .CLKS_PER_BIT     (CPB),
        .GAP_TIMEOUT_BITS (GTB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial     (rx_serial),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .err_corrected (err_corrected),
        .err_double    (err_double),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor: counts strobes cycle by cycle and latches the decoded values.
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         overlap_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_corr = 1'b0;
    logic       last_dbl = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                valid_cnt <= valid_cnt + 1;
                last_data <= data_out;
                last_corr <= err_corrected;
                last_dbl  <= err_double;
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (data_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: Hamming arithmetic on bit indices.
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] c = '0;
        int s = 0;
        for (int j = 0; j < 8; j++) c[DPOS[j]] = d[j];
        for (int i = 1; i <= 12; i++) if (c[i]) s = s ^ i;
        // Parity bit 2^k absorbs bit k of the data syndrome, zeroing the total.
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ($countones(c[12:1]) % 2) == 1;
        return c;
    endfunction

    // Returns {data, corrected, double}.
    function automatic logic [9:0] model_decode(input logic [12:0] c_in);
        logic [12:0] c = c_in;
        int   s = 0;
        logic p;
        logic corr, dbl;
        logic [7:0] d;
        for (int i = 1; i <= 12; i++) if (c[i]) s = s ^ i;
        p    = ($countones(c) % 2) == 1;
        corr = p && (s <= 12);
        dbl  = !corr && (s != 0);
        if (corr && s != 0) c[s] = ~c[s];
        for (int j = 0; j < 8; j++) d[j] = c[DPOS[j]];
        return {d, corr, dbl};
    endfunction

    task automatic line_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_serial = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 7; i >= 0; i--) line_bit(b[i]);
        line_bit(stop);
        rx_serial = 1'b1;
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input int gap,
                             input logic [7:0] exp_d, input logic exp_c, input logic exp_e,
                             input string tag);
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_byte(hi, 1'b1);
        if (gap > 0) idle_bits(gap);
        send_byte(lo, 1'b1);
        for (int i = 0; i < 4 * CPB && valid_cnt == v0; i++) @(negedge clk);
        idle_bits(1);
        chk({tag, "/valid_pulses"}, valid_cnt - v0, 1);
        chk({tag, "/data"}, {24'h0, last_data}, {24'h0, exp_d});
        chk({tag, "/corr"}, {31'h0, last_corr}, {31'h0, exp_c});
        chk({tag, "/dbl"}, {31'h0, last_dbl}, {31'h0, exp_e});
        chk({tag, "/no_frame_err"}, ferr_cnt - f0, 0);
    endtask

    logic [12:0] code;
    logic [9:0]  ref_out;
    int          v0, f0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("reset/data_out", {24'h0, data_out}, 0);
        chk("reset/data_valid", {31'h0, data_valid}, 0);
        chk("reset/err_corrected", {31'h0, err_corrected}, 0);
        chk("reset/err_double", {31'h0, err_double}, 0);
        chk("reset/frame_err", {31'h0, frame_err}, 0);
        rst_n = 1'b1;
        idle_bits(2);

        // Model sanity against the documented codeword
        code = encode(8'hA5);
        chk("model/encode_A5", {19'h0, code}, 32'h144E);

        send_pair(8'hA2, 8'h70, 0, 8'hA5, 1'b0, 1'b0, "clean");
        send_pair(8'hA0, 8'h70, 0, 8'hA5, 1'b1, 1'b0, "single");
        ref_out = model_decode({8'hA0, 5'b01111});
        send_pair(8'hA0, 8'h78, 0, ref_out[9:2], 1'b0, 1'b1, "double");

        // Bad stop bit on the high byte
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(8'hA2, 1'b0);
        idle_bits(3);
        chk("badstop/frame_err", ferr_cnt - f0, 1);
        chk("badstop/no_valid", valid_cnt - v0, 0);
        send_pair(8'hA2, 8'h70, 0, 8'hA5, 1'b0, 1'b0, "after_badstop");

        // Gap timeout after a lone high byte
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(8'hA2, 1'b1);
        idle_bits(5);
        chk("gap_timeout/frame_err", ferr_cnt - f0, 1);
        chk("gap_timeout/no_valid", valid_cnt - v0, 0);
        send_pair(8'hA2, 8'h70, 0, 8'hA5, 1'b0, 1'b0, "after_timeout");

        // Two-cycle glitch on an idle line
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(3);
        chk("glitch/no_frame_err", ferr_cnt - f0, 0);
        chk("glitch/no_valid", valid_cnt - v0, 0);
        send_pair(8'hA2, 8'h70, 0, 8'hA5, 1'b0, 1'b0, "after_glitch");

        // Reset during the low byte's data bits
        send_byte(8'hA2, 1'b1);
        line_bit(1'b0);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b1);
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset/data_out", {24'h0, data_out}, 0);
        chk("midreset/data_valid", {31'h0, data_valid}, 0);
        chk("midreset/err_corrected", {31'h0, err_corrected}, 0);
        chk("midreset/err_double", {31'h0, err_double}, 0);
        chk("midreset/frame_err", {31'h0, frame_err}, 0);
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rst_n = 1'b1;
        idle_bits(12);
        chk("midreset/no_stale_valid", valid_cnt - v0, 0);
        chk("midreset/no_stale_frame_err", ferr_cnt - f0, 0);
        send_pair(8'hA2, 8'h70, 0, 8'hA5, 1'b0, 1'b0, "after_reset");

        // Random codewords with 0, 1 or 2 flipped bits and random padding/gaps
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic [2:0] pad;
            int nerr, a, b, gap;
            d    = 8'($urandom_range(0, 255));
            pad  = 3'($urandom_range(0, 7));
            nerr = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            code = encode(d);
            a    = $urandom_range(0, 12);
            b    = (a + $urandom_range(1, 12)) % 13;
            if (nerr >= 1) code[a] = ~code[a];
            if (nerr == 2) code[b] = ~code[b];
            ref_out = model_decode(code);
            if (nerr < 2) chk("random/model_recovers", {24'h0, ref_out[9:2]}, {24'h0, d});
            send_pair(code[12:5], {code[4:0], pad}, gap,
                      ref_out[9:2], ref_out[1], ref_out[0], "random");
        end

        chk("never_valid_and_frame_err", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
